// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the irq_ctrl register window: word offsets and CLAIM layout.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IRQ_REG_PENDING = 2'd0,
        IRQ_REG_ENABLE  = 2'd1,
        IRQ_REG_EDGE    = 2'd2,
        IRQ_REG_CLAIM   = 2'd3
    } irq_reg_e;

    localparam int CLAIM_VALID_BIT = 31;
    localparam int IRQ_IDX_W       = 5;

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side register window bus of irq_ctrl (FemtoRV mem_* signals after address decode).
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic        select;
    logic [3:0]  we;
    logic        rd;
    irq_reg_e    addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output select, we, rd, addr, wdata, input rdata);
    modport slave  (input select, we, rd, addr, wdata, output rdata);
endinterface

// File: rtl/irq_src_cond.sv
// Per-source conditioning: sample stage, history flop, edge latch; optional 2-flop
// synchronizer in front when IRQ_SYNC_EN is defined.
module irq_src_cond (
    input  logic clk,
    input  logic resetq,
    input  logic src,
    input  logic edge_sel,
    input  logic clr,
    output logic pending
);
    logic src_q;
    logic s;
    logic prev;
    logic latch;
    logic set;

`ifdef IRQ_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) sync <= '0;
        else         sync <= {sync[0], src};
    end

    assign src_q = sync[1];
`else
    assign src_q = src;
`endif

    assign set = s & ~prev & edge_sel;

    // NOTE: non-blocking here so s, prev and latch all see pre-edge values.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            s     <= 1'b0;
            prev  <= 1'b0;
            latch <= 1'b0;
        end else begin
            s     <= src_q;
            prev  <= s;
            latch <= set | (latch & ~clr); // a new edge beats a simultaneous clear
        end
    end

    assign pending = edge_sel ? latch : s;
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source enable, level/edge select, W1C pending, priority claim.
// Define IRQ_SYNC_EN to add a 2-flop synchronizer on every source input.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               resetq,
    input  logic [NUM_SRC-1:0] irq_src,
    irq_ctrl_if.slave          bus,
    output logic               irq
);
    logic [NUM_SRC-1:0] enable_q, edge_q;
    logic [NUM_SRC-1:0] enable_d, edge_d;
    logic [NUM_SRC-1:0] wmask, wdata_n;
    logic [NUM_SRC-1:0] pending, active, clr;
    logic [NUM_SRC-1:0] w1c, edge_fall, claim_clr, claim_onehot;
    logic               wr, wr_pend, wr_enable, wr_edge;
    logic               claim_valid, claim_fire;
    logic [IRQ_IDX_W-1:0] claim_idx;

    assign wr        = bus.select & (|bus.we);
    assign wr_pend   = wr & (bus.addr == IRQ_REG_PENDING);
    assign wr_enable = wr & (bus.addr == IRQ_REG_ENABLE);
    assign wr_edge   = wr & (bus.addr == IRQ_REG_EDGE);
    assign wdata_n   = bus.wdata[NUM_SRC-1:0];

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) wmask[i] = bus.we[i/8];
    end

    assign enable_d = (enable_q & ~wmask) | (wdata_n & wmask);
    assign edge_d   = (edge_q & ~wmask) | (wdata_n & wmask);

    // Latch clears: W1C on edge bits, EDGE_SEL 1->0, and the claimed edge source.
    assign w1c        = wr_pend ? (wdata_n & wmask & edge_q) : '0;
    assign edge_fall  = wr_edge ? (edge_q & ~edge_d) : '0;
    assign claim_fire = bus.select & bus.rd & (bus.addr == IRQ_REG_CLAIM) & claim_valid;
    assign claim_clr  = claim_fire ? (claim_onehot & edge_q) : '0;
    assign clr        = w1c | edge_fall | claim_clr;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_src_cond u_cond (
            .clk      (clk),
            .resetq   (resetq),
            .src      (irq_src[i]),
            .edge_sel (edge_q[i]),
            .clr      (clr[i]),
            .pending  (pending[i])
        );
    end

    assign active      = pending & enable_q;
    assign claim_valid = |active;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        claim_idx    = '0;
        claim_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_idx       = IRQ_IDX_W'(i);
                claim_onehot    = '0;
                claim_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            enable_q <= '0;
            edge_q   <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_enable) enable_q <= enable_d;
            if (wr_edge)   edge_q   <= edge_d;
            irq <= |active;
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            IRQ_REG_PENDING: bus.rdata[NUM_SRC-1:0] = pending;
            IRQ_REG_ENABLE:  bus.rdata[NUM_SRC-1:0] = enable_q;
            IRQ_REG_EDGE:    bus.rdata[NUM_SRC-1:0] = edge_q;
            IRQ_REG_CLAIM: begin
                if (claim_valid) begin
                    bus.rdata[CLAIM_VALID_BIT]  = 1'b1;
                    bus.rdata[IRQ_IDX_W-1:0]    = claim_idx;
                end
            end
        endcase
    end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between the peripheral interrupt lines (GP timer, UART rx valid, Econet rx frame valid, Econet timer A, SD card detect) and the FemtoRV32 `interrupt_request` input.
- Replaces the plain OR of those lines.
- Adds per-source enable, level/edge selection, latched pending bits and a priority claim register.
- Sits on the CPU bus as a 4-word register window, decoded in the toplevel.

Parameters:
- NUM_SRC, 8, number of interrupt source inputs (1..32); bit i = source i; lower index = higher priority.

Ports:
- clk  in  1  system clock (CPU clock)
- resetq  in  1  asynchronous active-low reset
- irq_src  in  NUM_SRC  raw interrupt request lines from peripherals
- select  in  1  register window selected by the toplevel address decode
- we  in  4  CPU byte write mask (mem_wmask)
- rd  in  1  CPU read strobe (mem_rstrb)
- addr  in  2  word address within window (mem_addr[3:2])
- wdata  in  32  CPU write data
- rdata  out  32  register read data, combinational from addr
- irq  out  1  interrupt request to CPU, registered

Behaviour:
- Interface: one clock `clk`; reset `resetq` is asynchronous and active-low. All state clears on resetq=0 regardless of clk.
- Reset values: ENABLE=0, EDGE_SEL=0, edge-pending latches=0, source history flops=0, irq=0.
- Registers (addr):
  - 0 PENDING: read = pending vector. Write: each 1 bit clears the latched pending of an edge source (W1C). Level bits ignore writes.
  - 1 ENABLE: RW. Byte-lane writes honour we[3:0].
  - 2 EDGE_SEL: RW, byte lanes. 1 = rising-edge latched, 0 = level.
  - 3 CLAIM: read = {valid at bit31, 26'b0, index[4:0]}. Writes ignored.
- Bits at or above NUM_SRC read 0 and writes to them are discarded.
- Source conditioning:
  - s = sampled source; prev = s delayed one clk.
  - Edge pending sets when s & ~prev & EDGE_SEL[i].
  - Level pending[i] = s when EDGE_SEL[i]=0.
- Pending vector: pending[i] = EDGE_SEL[i] ? latch[i] : s[i].
- Simultaneous set and clear on the same edge bit (W1C or claim): set wins and the bit stays 1.
- Writing EDGE_SEL bit 1->0 clears that bit's latch in the same cycle.
- Edges latch regardless of ENABLE. Enabling later raises irq if a latch is already set.
- active = pending & ENABLE.
- irq is a register, updated every clk: irq <= |active. irq therefore trails `active` by one cycle.
- CLAIM: index = lowest set bit of active; valid = |active. If active=0, rdata = 0.
- Claim side effect: rd & select & addr==3 & valid & EDGE_SEL[index] clears latch[index] on that clk edge (set-wins rule still applies). Level sources are cleared only at the peripheral.
- A claim read and a write (any addr) are never simultaneous on the FemtoRV bus; no special handling is required.
- Latency without sync: source rises in cycle N -> pending visible N+1 -> irq high N+2.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: each irq_src bit passes through a 2-flop synchronizer before s, for asynchronous sources (e.g. Econet clock domain). Adds 2 cycles latency: irq high at N+4. Synchronizer flops reset to 0.
- Undefined: s = irq_src sampled by a single register stage; all sources must be clk-synchronous.

Decomposition:
- Shared package: register offsets IRQ_REG_PENDING=0, IRQ_REG_ENABLE=1, IRQ_REG_EDGE=2, IRQ_REG_CLAIM=3; CLAIM valid-bit position 31; index width 5.
- One sub-module, irq_src_cond, instantiated per source. It contains the optional synchronizer, the history flop and the edge latch with set/clear inputs, and outputs the pending bit.
- Priority encode and register file stay in irq_ctrl.

Test Plan:
- Reset: hold resetq=0 mid-operation with latches set -> all registers read 0, irq=0 immediately; no clk edge needed.
- Level path: ENABLE=0x01, EDGE_SEL=0, irq_src=0x01 -> PENDING=0x01, irq=1 two cycles after the source rises. Drop the source -> irq=0 two cycles later.
- Edge latch and W1C: EDGE_SEL=0x04, ENABLE=0x04, 1-cycle pulse on src2 -> PENDING=0x04 persists, CLAIM=0x80000002. Write PENDING=0x04 -> PENDING=0, irq=0 next cycle.
- Priority claim: ENABLE=0xFF, EDGE_SEL=0xFF, pulse src5 and src1 together -> CLAIM=0x80000001 (src1 cleared), then 0x80000005, then 0x00000000; irq falls after the second claim.
- Set-wins: edge on src3 in the same cycle as a W1C write of 0x08 -> PENDING bit3 remains 1.
- Byte lanes and masking: write ENABLE=0xFFFFFFFF with we=4'b0001, NUM_SRC=8 -> ENABLE reads 0x000000FF. Write with we=4'b0010 -> unchanged.
